// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection, stall/bubble control, multiply hold and EXE forwarding selects for a 5-stage pipeline.
// Optional feature macro HAZARD_FWD_EN: forwarding enabled (only load-use stalls); undefined, EXE/MEM writers stall ID.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_use,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_mem_r_en,
  input  logic                          id_is_mul,
  input  logic                          flush,
  output logic                          freeze,
  output logic                          id_bubble,
  output logic                          exe_hold,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic [CNT_W-1:0]              stall_cnt
);
  localparam int MC_W = $clog2(MUL_LAT + 1);
  localparam logic [MC_W-1:0] MUL_RELOAD = MC_W'(MUL_LAT - 1);

  logic                               exe_valid_reg, exe_wb_en_reg, exe_mem_r_reg, exe_is_mul_reg;
  logic [REG_ADDR_W-1:0]              exe_dest_reg;
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] exe_src_reg;
  logic [NUM_SRC-1:0]                 exe_src_use_reg;
  logic                               mem_valid_reg, mem_wb_en_reg, mem_mem_r_reg;
  logic [REG_ADDR_W-1:0]              mem_dest_reg;
  logic                               wb_valid_reg, wb_wb_en_reg;
  logic [REG_ADDR_W-1:0]              wb_dest_reg;
  logic [MC_W-1:0]                    mul_cnt_reg;
  logic [CNT_W-1:0]                   stall_cnt_reg;

  logic               busy, hazard, stall;
  logic [NUM_SRC-1:0] src_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] src;
      logic                  exe_match;
      assign src       = id_src[gi*REG_ADDR_W +: REG_ADDR_W];
      assign exe_match = exe_valid_reg && exe_wb_en_reg && (exe_dest_reg == src);
`ifdef HAZARD_FWD_EN
      // Only a load still in EXE cannot be forwarded in time.
      assign src_hit[gi] = id_valid && id_src_use[gi] && (src != '0) && exe_match && exe_mem_r_reg;
`else
      logic mem_match;
      assign mem_match   = mem_valid_reg && mem_wb_en_reg && (mem_dest_reg == src);
      assign src_hit[gi] = id_valid && id_src_use[gi] && (src != '0) && (exe_match || mem_match);
`endif
    end
  endgenerate

  assign busy   = (mul_cnt_reg != '0);
  assign hazard = |src_hit;
  assign stall  = !busy && !flush && hazard;

  assign freeze    = !rst && (busy || stall);
  assign id_bubble = !rst && !busy && (flush || hazard);
  assign exe_hold  = !rst && busy && exe_is_mul_reg;
  assign stall_cnt = rst ? '0 : stall_cnt_reg;

`ifdef HAZARD_FWD_EN
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      logic [REG_ADDR_W-1:0] esrc;
      logic [1:0]            sel;
      assign esrc = exe_src_reg[gi];
      // MEM wins over WB because it holds the younger result.
      always_comb begin
        sel = 2'd0;
        if (!rst && exe_valid_reg && exe_src_use_reg[gi] && (esrc != '0)) begin
          if (mem_valid_reg && mem_wb_en_reg && !mem_mem_r_reg && (mem_dest_reg == esrc))
            sel = 2'd2;
          else if (wb_valid_reg && wb_wb_en_reg && (wb_dest_reg == esrc))
            sel = 2'd1;
        end
      end
      assign fwd_sel[2*gi +: 2] = sel;
    end
  endgenerate
`else
  assign fwd_sel = '0;
  logic unused_nofwd;
  assign unused_nofwd = ^{exe_mem_r_reg, exe_src_reg, exe_src_use_reg, mem_mem_r_reg,
                          wb_valid_reg, wb_dest_reg, wb_wb_en_reg};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_reg <= 1'b0;
      mem_valid_reg <= 1'b0;
      wb_valid_reg  <= 1'b0;
      mul_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      wb_valid_reg <= mem_valid_reg;
      wb_dest_reg  <= mem_dest_reg;
      wb_wb_en_reg <= mem_wb_en_reg;
      if (busy) begin
        // Multiply keeps EXE; a bubble drains into MEM behind it.
        mul_cnt_reg   <= mul_cnt_reg - MC_W'(1);
        mem_valid_reg <= 1'b0;
      end else begin
        mem_valid_reg <= exe_valid_reg;
        mem_dest_reg  <= exe_dest_reg;
        mem_wb_en_reg <= exe_wb_en_reg;
        mem_mem_r_reg <= exe_mem_r_reg;
        if (flush || hazard) begin
          exe_valid_reg <= 1'b0;
        end else begin
          exe_valid_reg   <= id_valid;
          exe_dest_reg    <= id_dest;
          exe_wb_en_reg   <= id_wb_en;
          exe_mem_r_reg   <= id_mem_r_en;
          exe_is_mul_reg  <= id_is_mul;
          exe_src_reg     <= id_src;
          exe_src_use_reg <= id_src_use;
          if (id_valid && id_is_mul)
            mul_cnt_reg <= MUL_RELOAD;
        end
      end
      if ((busy || stall) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed pipeline scenarios plus random traffic
// checked against an instruction-level reference model; a second instance uses a 2-bit stall counter.
module tb_hazard_scoreboard_unit;
  localparam int W  = 5;
  localparam int NS = 2;
  localparam int ML = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [NS*W-1:0] id_src;
  logic [NS-1:0] id_src_use;
  logic [W-1:0]  id_dest;
  logic          id_wb_en, id_mem_r_en, id_is_mul, flush;
  logic          freeze, id_bubble, exe_hold;
  logic [2*NS-1:0] fwd_sel;
  logic [15:0]   stall_cnt;
  logic          s_freeze, s_id_bubble, s_exe_hold;
  logic [2*NS-1:0] s_fwd_sel;
  logic [1:0]    s_stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .MUL_LAT(ML), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_is_mul(id_is_mul),
    .flush(flush), .freeze(freeze), .id_bubble(id_bubble), .exe_hold(exe_hold),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt));

  hazard_scoreboard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .MUL_LAT(ML), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_is_mul(id_is_mul),
    .flush(flush), .freeze(s_freeze), .id_bubble(s_id_bubble), .exe_hold(s_exe_hold),
    .fwd_sel(s_fwd_sel), .stall_cnt(s_stall_cnt));

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       wb, ld, mul;
    logic [4:0] src0, src1;
    logic       u0, u1;
  } instr_t;

  localparam instr_t NOP = '0;

  // Reference model: the instruction sitting in each stage, remaining multiply cycles, stall total.
  instr_t m_exe, m_mem, m_wb, cur;
  int     busy_left, stalls;
  bit     cur_flush, exp_freeze;
  int     n_checks = 0, n_fail = 0, cyc = 0;
  int     c0;

  function automatic instr_t alu(logic [4:0] d, logic [4:0] s0, logic [4:0] s1);
    instr_t r = '0;
    r.v = 1; r.wb = 1; r.dest = d; r.src0 = s0; r.src1 = s1; r.u0 = 1; r.u1 = 1;
    return r;
  endfunction

  function automatic instr_t load(logic [4:0] d, logic [4:0] s0);
    instr_t r = '0;
    r.v = 1; r.wb = 1; r.ld = 1; r.dest = d; r.src0 = s0; r.u0 = 1;
    return r;
  endfunction

  function automatic instr_t mulop(logic [4:0] d, logic [4:0] s0, logic [4:0] s1);
    instr_t r = alu(d, s0, s1);
    r.mul = 1;
    return r;
  endfunction

  function automatic logic [1:0] fwd_for(logic [4:0] s, logic u);
    if (!FWD || !m_exe.v || !u || s == 5'd0) return 2'd0;
    if (m_mem.v && m_mem.wb && !m_mem.ld && m_mem.dest == s) return 2'd2;
    if (m_wb.v && m_wb.wb && m_wb.dest == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit blocked(logic [4:0] s);
    if (FWD) return m_exe.v && m_exe.wb && m_exe.ld && m_exe.dest == s;
    return (m_exe.v && m_exe.wb && m_exe.dest == s) || (m_mem.v && m_mem.wb && m_mem.dest == s);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit haz, busy, e_bub;
    logic [3:0] e_fwd;
    int e_sat;
    @(negedge clk);
    rst         = 1'b0;
    id_valid    = cur.v;
    id_src      = {cur.src1, cur.src0};
    id_src_use  = {cur.u1, cur.u0};
    id_dest     = cur.dest;
    id_wb_en    = cur.wb;
    id_mem_r_en = cur.ld;
    id_is_mul   = cur.mul;
    flush       = cur_flush;
    #1;
    haz = (cur.v && cur.u0 && cur.src0 != 5'd0 && blocked(cur.src0)) ||
          (cur.v && cur.u1 && cur.src1 != 5'd0 && blocked(cur.src1));
    busy       = busy_left > 0;
    exp_freeze = busy || (!cur_flush && haz);
    e_bub      = !busy && (cur_flush || haz);
    e_fwd      = {fwd_for(m_exe.src1, m_exe.u1), fwd_for(m_exe.src0, m_exe.u0)};
    e_sat      = (stalls > 3) ? 3 : stalls;
    check("freeze", freeze, exp_freeze);
    check("id_bubble", id_bubble, e_bub);
    check("exe_hold", exe_hold, busy);
    check("fwd_sel", fwd_sel, e_fwd);
    check("stall_cnt", stall_cnt, stalls);
    check("sat_freeze", s_freeze, exp_freeze);
    check("sat_id_bubble", s_id_bubble, e_bub);
    check("sat_exe_hold", s_exe_hold, busy);
    check("sat_fwd_sel", s_fwd_sel, e_fwd);
    check("sat_stall_cnt", s_stall_cnt, e_sat);
    $display("cyc %0d v=%0b src=%0d,%0d dst=%0d flush=%0b | freeze=%0b bub=%0b hold=%0b fwd=%h cnt=%0d",
             cyc, cur.v, cur.src0, cur.src1, cur.dest, cur_flush, freeze, id_bubble, exe_hold,
             fwd_sel, stall_cnt);
    cyc++;
    m_wb = m_mem;
    if (busy) begin
      m_mem.v = 1'b0;
      busy_left--;
      stalls++;
    end else begin
      m_mem = m_exe;
      if (cur_flush) m_exe.v = 1'b0;
      else if (haz) begin
        m_exe.v = 1'b0;
        stalls++;
      end else begin
        m_exe = cur;
        if (cur.v && cur.mul) busy_left = ML - 1;
      end
    end
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst       = 1'b1;
    id_valid  = 1'b1;
    flush     = 1'b1;
    id_is_mul = 1'b1;
    #1;
    check("rst_freeze", freeze, 0);
    check("rst_id_bubble", id_bubble, 0);
    check("rst_exe_hold", exe_hold, 0);
    check("rst_fwd_sel", fwd_sel, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_sat_stall_cnt", s_stall_cnt, 0);
    $display("cyc %0d reset", cyc);
    cyc++;
    m_exe = NOP; m_mem = NOP; m_wb = NOP;
    busy_left = 0;
    stalls = 0;
  endtask

  task automatic step(instr_t ins);
    cur = ins;
    cur_flush = 1'b0;
    cycle();
  endtask

  // Present one instruction until the model says ID is no longer frozen.
  task automatic issue_until(instr_t ins);
    int n = 0;
    step(ins);
    while (exp_freeze && n < 20) begin
      n++;
      cycle();
    end
    check("issue_bound", n < 20, 1);
  endtask

  task automatic drain();
    repeat (3) step(NOP);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_src = '0; id_src_use = '0; id_dest = '0;
    id_wb_en = 0; id_mem_r_en = 0; id_is_mul = 0; flush = 0;
    m_exe = NOP; m_mem = NOP; m_wb = NOP; busy_left = 0; stalls = 0;
    cur = NOP; cur_flush = 0;

    rst_cycle();
    rst_cycle();
    step(NOP);
    check("post_rst_freeze", freeze, 0);

    // add r3 ; or r7,r3,r0 ; independent op
    drain();
    c0 = stall_cnt;
    step(alu(5'd3, 5'd1, 5'd2));
    issue_until(alu(5'd7, 5'd3, 5'd0));
    step(alu(5'd9, 5'd1, 5'd4));
    check("A_stalls", stall_cnt - c0, FWD ? 0 : 2);
    check("A_fwd", fwd_sel, FWD ? 2 : 0);
    step(NOP);
    check("A_indep_fwd", fwd_sel, 0);

    // lw r5 ; add r6,r5,r5
    drain();
    c0 = stall_cnt;
    step(load(5'd5, 5'd1));
    issue_until(alu(5'd6, 5'd5, 5'd5));
    step(NOP);
    check("B_stalls", stall_cnt - c0, FWD ? 1 : 2);
    check("B_fwd", fwd_sel, FWD ? 4'b0101 : 0);

    // mul r2 ; add r8,r2,r2
    drain();
    c0 = stall_cnt;
    step(mulop(5'd2, 5'd1, 5'd1));
    step(alu(5'd8, 5'd2, 5'd2));
    check("C_busy_hold", exe_hold, 1);
    issue_until(alu(5'd8, 5'd2, 5'd2));
    step(NOP);
    check("C_stalls", stall_cnt - c0, FWD ? 3 : 5);
    check("C_fwd", fwd_sel, FWD ? 4'b1010 : 0);
    check("C_sat", s_stall_cnt, 3);

    // flush with a pending load-use hazard
    drain();
    step(load(5'd5, 5'd1));
    cur = alu(5'd6, 5'd5, 5'd5);
    cur_flush = 1'b1;
    cycle();
    check("D_bubble", id_bubble, 1);
    check("D_freeze", freeze, 0);
    c0 = stall_cnt;
    step(NOP);
    check("D_stalls", stall_cnt - c0, 0);

    // r0 source never stalls
    drain();
    step(load(5'd0, 5'd1));
    step(alu(5'd6, 5'd0, 5'd0));
    check("E_r0_freeze", freeze, 0);

    // reset during the second busy cycle of a multiply
    drain();
    step(mulop(5'd2, 5'd1, 5'd1));
    step(NOP);
    check("F_busy1", exe_hold, 1);
    rst_cycle();
    step(NOP);
    check("F_hold", exe_hold, 0);
    check("F_freeze", freeze, 0);

    // stall counter saturation after reset: mul-use plus two load-uses
    step(mulop(5'd2, 5'd1, 5'd1));
    issue_until(alu(5'd8, 5'd2, 5'd2));
    drain();
    step(load(5'd5, 5'd1));
    issue_until(alu(5'd6, 5'd5, 5'd5));
    drain();
    step(load(5'd4, 5'd1));
    issue_until(alu(5'd6, 5'd4, 5'd1));
    step(NOP);
    check("G_cnt", stall_cnt, FWD ? 5 : 9);
    check("G_sat", s_stall_cnt, 3);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_cycle();
        cur = NOP;
        cur_flush = 1'b0;
      end else begin
        cur.v    = ($urandom_range(0, 3) != 0);
        cur.dest = 5'($urandom_range(0, 7));
        cur.src0 = 5'($urandom_range(0, 7));
        cur.src1 = 5'($urandom_range(0, 7));
        cur.u0   = ($urandom_range(0, 3) != 0);
        cur.u1   = ($urandom_range(0, 1) != 0);
        cur.wb   = ($urandom_range(0, 4) != 0);
        cur.ld   = ($urandom_range(0, 3) == 0);
        cur.mul  = !cur.ld && ($urandom_range(0, 7) == 0);
        cur_flush = ($urandom_range(0, 9) == 0);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
